// File: rtl/tx_frame_arbiter.sv
// Purpose: per-frame round-robin arbiter sharing one UART TX byte path between two producers.
// Latency: one cycle to arbitrate in IDLE; the owner's bytes pass to TX combinationally (zero cycles).
// Backpressure: the owner's READY follows TX_READY_I; the non-owner and the IDLE state see READY low.
// Ports: CLK_I/RST_I clock and synchronous active-high reset;
//        REQx_VALID_I/REQx_DATA_I/REQx_LAST_I/REQx_READY_O are the producer byte streams;
//        TX_READY_I/TX_WRITE_O/TX_DATA_O form the UART TX byte path;
//        GRANT_O is the one-hot owner (00 idle); ABORT_O pulses for one cycle on a watchdog release.
module tx_frame_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_FRAME    = 64,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  REQ0_VALID_I,
  input  logic [DATA_WIDTH-1:0] REQ0_DATA_I,
  input  logic                  REQ0_LAST_I,
  output logic                  REQ0_READY_O,
  input  logic                  REQ1_VALID_I,
  input  logic [DATA_WIDTH-1:0] REQ1_DATA_I,
  input  logic                  REQ1_LAST_I,
  output logic                  REQ1_READY_O,
  input  logic                  TX_READY_I,
  output logic                  TX_WRITE_O,
  output logic [DATA_WIDTH-1:0] TX_DATA_O,
  output logic [1:0]            GRANT_O,
  output logic                  ABORT_O
);

  localparam int BEAT_W = $clog2(MAX_FRAME + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT);
  // Beat count just before the beat that fills the frame.
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_FRAME - 1);
  // The idle watchdog fires on the quiet cycle that would carry the counter to IDLE_TIMEOUT-1.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 2);

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t                state, state_nxt;
  logic                  ptr, ptr_nxt;      // 1 favours requester 1 on a contested arbitration
  logic                  abort_q, abort_nxt;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [IDLE_W-1:0]     idle_cnt;
  logic                  own_valid;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  beat;
  logic                  rel;
  logic                  rel_forced;

  // Owner mux: everything reads zero outside an OWN state.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    case (state)
      OWN0: begin
        own_valid = REQ0_VALID_I;
        own_last  = REQ0_LAST_I;
        own_data  = REQ0_DATA_I;
      end
      OWN1: begin
        own_valid = REQ1_VALID_I;
        own_last  = REQ1_LAST_I;
        own_data  = REQ1_DATA_I;
      end
      default: ;
    endcase
  end

  // Nothing is accepted during a reset cycle, so the dropped frame cannot leak a byte.
  assign beat         = own_valid & TX_READY_I & ~RST_I;
  assign TX_WRITE_O   = beat;
  assign TX_DATA_O    = own_data;
  assign REQ0_READY_O = (state == OWN0) & TX_READY_I & ~RST_I;
  assign REQ1_READY_O = (state == OWN1) & TX_READY_I & ~RST_I;
  assign GRANT_O      = state;
  assign ABORT_O      = abort_q;

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    abort_nxt  = 1'b0;
    rel        = 1'b0;
    rel_forced = 1'b0;
    case (state)
      IDLE: begin
        if (REQ0_VALID_I && REQ1_VALID_I) state_nxt = ptr ? OWN1 : OWN0;
        else if (REQ0_VALID_I)            state_nxt = OWN0;
        else if (REQ1_VALID_I)            state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (beat) begin
          // LAST wins over a simultaneous max-length hit: a clean end of frame.
          if (own_last) begin
            rel = 1'b1;
          end else if (beat_cnt == BEAT_LAST) begin
            rel        = 1'b1;
            rel_forced = 1'b1;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          rel        = 1'b1;
          rel_forced = 1'b1;
        end
        if (rel) begin
          state_nxt = IDLE;
          ptr_nxt   = (state == OWN0);
          abort_nxt = rel_forced;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      abort_q  <= 1'b0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      abort_q <= abort_nxt;
      // Counters only run while a grant is held and survives this cycle.
      if (state == IDLE || state_nxt == IDLE) begin
        beat_cnt <= '0;
        idle_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 1'b1;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Purpose: scoreboard bench for tx_frame_arbiter: directed frames plus randomized traffic.
// Latency: expectations come from a cycle-level reference of the arbitration rules.
// Backpressure: producers hold each byte until the DUT shows ready; TX_READY_I is toggled.
module tb_tx_frame_arbiter;

  localparam int DW = 8;
  localparam int MF = 4;
  localparam int IT = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          v0 = 1'b0, l0 = 1'b0, v1 = 1'b0, l1 = 1'b0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic          txr = 1'b1;
  logic          r0_o, r1_o, tx_wr, abort_o;
  logic [DW-1:0] tx_dat;
  logic [1:0]    grant_o;

  always #5 clk = ~clk;

  tx_frame_arbiter #(.DATA_WIDTH(DW), .MAX_FRAME(MF), .IDLE_TIMEOUT(IT)) dut (
    .CLK_I(clk), .RST_I(rst),
    .REQ0_VALID_I(v0), .REQ0_DATA_I(d0), .REQ0_LAST_I(l0), .REQ0_READY_O(r0_o),
    .REQ1_VALID_I(v1), .REQ1_DATA_I(d1), .REQ1_LAST_I(l1), .REQ1_READY_O(r1_o),
    .TX_READY_I(txr), .TX_WRITE_O(tx_wr), .TX_DATA_O(tx_dat),
    .GRANT_O(grant_o), .ABORT_O(abort_o)
  );

  typedef struct {
    bit            gap;
    logic [DW-1:0] d;
    bit            last;
  } item_t;

  item_t         q0[$], q1[$];
  bit            hs0, hs1;
  bit            rand_mode = 1'b0;
  int            cyc = 0;
  int            n_cmp = 0, n_bad = 0;
  logic [DW-1:0] exp_q[$];
  int            exp_abort[$];
  logic [DW-1:0] tx_log[$];
  int            abort_cnt = 0;
  int            last_write_cyc = 0, last_abort_cyc = 0;

  // Reference state: who owns the channel, whose turn it is, and frame progress.
  int            m_own = -1;
  int            m_ptr = 0;
  int            m_beats = 0;
  int            m_quiet = 0;
  logic [1:0]    exp_grant = 2'b00;
  bit            exp_r0 = 1'b0, exp_r1 = 1'b0;
  bit            m_v, m_l;
  logic [DW-1:0] m_d;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model, evaluated mid-cycle on the stable inputs.
  always @(negedge clk) begin
    hs0 = v0 & r0_o;
    hs1 = v1 & r1_o;
    exp_grant = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
    exp_r0    = (m_own == 0) && txr && !rst;
    exp_r1    = (m_own == 1) && txr && !rst;
    if (rst) begin
      m_own = -1; m_ptr = 0; m_beats = 0; m_quiet = 0;
    end else if (m_own < 0) begin
      if (v0 && v1)  m_own = m_ptr;
      else if (v0)   m_own = 0;
      else if (v1)   m_own = 1;
    end else begin
      m_v = (m_own == 0) ? v0 : v1;
      m_l = (m_own == 0) ? l0 : l1;
      m_d = (m_own == 0) ? d0 : d1;
      if (m_v && txr) begin
        exp_q.push_back(m_d);
        m_beats = m_beats + 1;
        m_quiet = 0;
        if (m_l) begin
          m_ptr = 1 - m_own; m_own = -1; m_beats = 0;
        end else if (m_beats == MF) begin
          exp_abort.push_back(cyc + 1);
          m_ptr = 1 - m_own; m_own = -1; m_beats = 0;
        end
      end else begin
        m_quiet = m_quiet + 1;
        if (m_quiet == IT - 1) begin
          exp_abort.push_back(cyc + 1);
          m_ptr = 1 - m_own; m_own = -1; m_beats = 0; m_quiet = 0;
        end
      end
    end
  end

  // Monitor: compares what the DUT presents against the scoreboard.
  always @(negedge clk) begin
    #1;
    n_cmp++;
    if (grant_o !== exp_grant || r0_o !== exp_r0 || r1_o !== exp_r1 ||
        (exp_grant == 2'b00 && tx_dat !== 8'h00)) begin
      n_bad++;
      $display("FAIL cycle_state @%0d: grant=%b rdy0=%b rdy1=%b data=%h, required grant=%b rdy0=%b rdy1=%b%s",
               cyc, grant_o, r0_o, r1_o, tx_dat, exp_grant, exp_r0, exp_r1,
               (exp_grant == 2'b00) ? " data=00" : "");
    end
    if (tx_wr !== 1'b0) begin
      tx_log.push_back(tx_dat);
      last_write_cyc = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL tx_byte @%0d: write=%b data=%h, required no write", cyc, tx_wr, tx_dat);
      end else if (tx_wr !== 1'b1 || tx_dat !== exp_q[0]) begin
        n_bad++;
        $display("FAIL tx_byte @%0d: write=%b data=%h, required write=1 data=%h", cyc, tx_wr, tx_dat, exp_q[0]);
        exp_q.delete(0);
      end else begin
        exp_q.delete(0);
      end
    end
    if (abort_o !== 1'b0) begin
      abort_cnt++;
      last_abort_cyc = cyc;
      n_cmp++;
      if (exp_abort.size() == 0) begin
        n_bad++;
        $display("FAIL abort @%0d: abort=%b, required no abort", cyc, abort_o);
      end else begin
        if (abort_o !== 1'b1 || exp_abort[0] != cyc) begin
          n_bad++;
          $display("FAIL abort @%0d: abort=%b, required pulse at cycle %0d", cyc, abort_o, exp_abort[0]);
        end
        exp_abort.delete(0);
      end
    end
  end

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic add(int r, logic [DW-1:0] d, bit last);
    item_t it;
    it.gap = 1'b0; it.d = d; it.last = last;
    if (r == 0) q0.push_back(it); else q1.push_back(it);
  endtask

  task automatic gap(int r, int n);
    for (int i = 0; i < n; i++) begin
      item_t it;
      it.gap = 1'b1; it.d = '0; it.last = 1'b0;
      if (r == 0) q0.push_back(it); else q1.push_back(it);
    end
  endtask

  task automatic gen_frame(int r);
    int len = $urandom_range(1, 6);
    for (int i = 0; i < len; i++) begin
      int k = $urandom_range(0, 19);
      if (k == 19)     gap(r, IT + 2);
      else if (k >= 15) gap(r, $urandom_range(1, 3));
      add(r, 8'($urandom), (i == len - 1) && ($urandom_range(0, 7) != 0));
    end
  endtask

  // One clock: retire accepted bytes, then present the next item of each producer.
  task automatic step();
    @(posedge clk);
    #1;
    if (hs0 && q0.size() > 0) q0.delete(0);
    if (hs1 && q1.size() > 0) q1.delete(0);
    if (rand_mode) begin
      if (q0.size() < 2) gen_frame(0);
      if (q1.size() < 2) gen_frame(1);
      txr = ($urandom_range(0, 99) < 85);
      rst = ($urandom_range(0, 699) == 0);
    end
    if (q0.size() > 0 && q0[0].gap) begin q0.delete(0); v0 = 1'b0; end
    else if (q0.size() > 0) begin v0 = 1'b1; d0 = q0[0].d; l0 = q0[0].last; end
    else v0 = 1'b0;
    if (!v0) begin d0 = 8'($urandom); l0 = 1'($urandom); end
    if (q1.size() > 0 && q1[0].gap) begin q1.delete(0); v1 = 1'b0; end
    else if (q1.size() > 0) begin v1 = 1'b1; d1 = q1[0].d; l1 = q1[0].last; end
    else v1 = 1'b0;
    if (!v1) begin d1 = 8'($urandom); l1 = 1'($urandom); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_quiet(int budget);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !v0 && !v1 && grant_o == 2'b00) && n < budget) begin
      step();
      n++;
    end
    chk("drain_within_budget", (n < budget) ? 1 : 0, 1);
    repeat (3) step();
  endtask

  task automatic wait_log(int cnt, int budget);
    int n = 0;
    while (tx_log.size() < cnt && n < budget) begin
      step();
      n++;
    end
    chk("first_byte_within_budget", (n < budget) ? 1 : 0, 1);
  endtask

  task automatic check_log(string nm, logic [63:0] exp_vec, int n);
    string a = "", e = "";
    bit ok = (tx_log.size() == n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b = exp_vec[(n - 1 - i) * 8 +: 8];
      e = {e, $sformatf("%h ", b)};
      if (i < tx_log.size() && tx_log[i] !== b) ok = 1'b0;
    end
    for (int i = 0; i < tx_log.size() && i < 16; i++) a = {a, $sformatf("%h ", tx_log[i])};
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: tx bytes %s(count %0d), required %s", nm, a, tx_log.size(), e);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int a0;
    // Reset state.
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset_grant", int'(grant_o), 0);
    chk("reset_write", int'(tx_wr), 0);
    chk("reset_abort", int'(abort_o), 0);
    chk("reset_ready0", int'(r0_o), 0);
    chk("reset_ready1", int'(r1_o), 0);
    chk("reset_data", int'(tx_dat), 0);

    // Single REQ0 frame AA BB CC.
    tx_log.delete(); a0 = abort_cnt;
    add(0, 8'hAA, 0); add(0, 8'hBB, 0); add(0, 8'hCC, 1);
    step();
    step();
    #1;
    chk("grant_after_valid", int'(grant_o), 1);
    wait_quiet(100);
    check_log("frame_aabbcc", 64'hAABBCC, 3);
    chk("frame_aabbcc_aborts", abort_cnt - a0, 0);

    // Contention from reset: frames alternate.
    do_reset();
    tx_log.delete();
    add(0, 8'h11, 0); add(0, 8'h12, 1); add(0, 8'h13, 0); add(0, 8'h14, 1);
    add(1, 8'h21, 0); add(1, 8'h22, 1); add(1, 8'h23, 0); add(1, 8'h24, 1);
    wait_quiet(100);
    check_log("round_robin_order", 64'h1112212213142324, 8);

    // REQ1 frame stalled by TX_READY_I low for 5 cycles.
    tx_log.delete();
    add(1, 8'h31, 0); add(1, 8'h32, 0); add(1, 8'h33, 1);
    wait_log(1, 50);
    txr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk("stall_write", int'(tx_wr), 0);
      chk("stall_ready1", int'(r1_o), 0);
      chk("stall_grant", int'(grant_o), 2);
    end
    txr = 1'b1;
    wait_quiet(100);
    check_log("stalled_frame", 64'h313233, 3);

    // Max-length release with REQ1 waiting.
    do_reset();
    tx_log.delete(); a0 = abort_cnt;
    add(0, 8'h01, 0); add(0, 8'h02, 0); add(0, 8'h03, 0);
    add(0, 8'h04, 0); add(0, 8'h05, 0); add(0, 8'h06, 0);
    add(1, 8'hA1, 0); add(1, 8'hA2, 1);
    wait_quiet(200);
    check_log("max_frame_release", 64'h01020304A1A20506, 8);
    chk("max_frame_aborts", abort_cnt - a0, 2);

    // Idle timeout after a lone byte, then pointer favours REQ1.
    do_reset();
    tx_log.delete(); a0 = abort_cnt;
    add(0, 8'h51, 0);
    wait_quiet(100);
    chk("timeout_aborts", abort_cnt - a0, 1);
    chk("timeout_delay", last_abort_cyc - last_write_cyc, IT);
    add(0, 8'h52, 1); add(1, 8'h61, 1);
    wait_quiet(100);
    check_log("pointer_after_timeout", 64'h516152, 3);

    // Reset in the middle of a REQ1 frame.
    do_reset();
    tx_log.delete(); a0 = abort_cnt;
    add(1, 8'h71, 0); add(1, 8'h72, 0); add(1, 8'h73, 1);
    wait_log(1, 50);
    rst = 1'b1;
    add(0, 8'h81, 1);
    step();
    rst = 1'b0;
    #1;
    chk("midreset_grant", int'(grant_o), 0);
    chk("midreset_write", int'(tx_wr), 0);
    chk("midreset_abort", int'(abort_o), 0);
    wait_quiet(100);
    check_log("after_midreset", 64'h71817273, 4);
    chk("midreset_aborts", abort_cnt - a0, 0);

    // Randomized traffic against the reference model.
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    rst = 1'b0;
    txr = 1'b1;
    wait_quiet(500);
    chk("leftover_expected_bytes", exp_q.size(), 0);
    chk("leftover_expected_aborts", exp_abort.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Shares the single UART TX byte path (uart TX ready / write / data) between two frame-oriented byte producers: requester 0 is the TX escape/TAP response stream and requester 1 is a secondary stream such as STB status notifications.
- Grants ownership per frame, so escape sequences and frames from the two producers never interleave on the wire.
- Round-robin fairness, with watchdogs that reclaim the channel from a stalled or runaway owner.

Parameters:
- DATA_WIDTH, 8, byte width of the TX path.
- MAX_FRAME, 64, maximum beats per granted frame before forced release (>=1).
- IDLE_TIMEOUT, 1024, cycles without a transfer while granted before forced release (>=2).

Ports:
- CLK_I  in  1  clock; single clock domain.
- RST_I  in  1  reset; synchronous, active-high.
- REQ0_VALID_I  in  1  requester 0 byte valid.
- REQ0_DATA_I  in  DATA_WIDTH  requester 0 byte.
- REQ0_LAST_I  in  1  requester 0 final byte of frame; qualified by valid.
- REQ0_READY_O  out  1  requester 0 byte accepted.
- REQ1_VALID_I  in  1  requester 1 byte valid.
- REQ1_DATA_I  in  DATA_WIDTH  requester 1 byte.
- REQ1_LAST_I  in  1  requester 1 final byte of frame.
- REQ1_READY_O  out  1  requester 1 byte accepted.
- TX_READY_I  in  1  UART TX can take a byte.
- TX_WRITE_O  out  1  write strobe to UART TX.
- TX_DATA_O  out  DATA_WIDTH  byte to UART TX.
- GRANT_O  out  2  one-hot current owner; 00 when idle.
- ABORT_O  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (sync, RST_I=1 at a clock edge), applied regardless of state, mid-frame included; the partial frame is dropped with no ABORT_O:
  - state=IDLE, priority pointer=0, beat counter=0, idle counter=0.
  - GRANT_O=00, ABORT_O=0.
  - TX_WRITE_O=0, TX_DATA_O=0.
  - REQx_READY_O=0.
- FSM states: IDLE, OWN0, OWN1. GRANT_O is registered and equals the state (OWN0=01, OWN1=10).
- IDLE:
  - If exactly one REQx_VALID_I=1, go to OWNx next cycle.
  - If both are valid, go to OWN[pointer].
  - If neither is valid, stay in IDLE.
  - Arbitration latency is 1 cycle. No bytes transfer in IDLE; both READY_O=0.
- OWNx datapath (combinational pass-through, zero latency):
  - TX_DATA_O = REQx_DATA_I.
  - TX_WRITE_O = REQx_VALID_I & TX_READY_I.
  - REQx_READY_O = TX_READY_I.
  - The non-owner's READY_O=0.
  - Transfer (beat) = REQx_VALID_I & TX_READY_I.
- TX_DATA_O=0 whenever not in an OWN state.
- Beat counter (width clog2(MAX_FRAME+1)) increments on each beat and clears on leaving OWNx.
- Idle counter (width clog2(IDLE_TIMEOUT)) clears on a beat and increments otherwise.
- Normal release: a beat with REQx_LAST_I=1 returns to IDLE next cycle, pointer = 1-x. No ABORT_O.
- Max-length release: a beat that makes beat count == MAX_FRAME with LAST=0 returns to IDLE, pointer = 1-x, and ABORT_O=1 for one cycle (registered, coincides with IDLE entry).
- Idle-timeout release: idle counter reaching IDLE_TIMEOUT-1 with no beat that cycle returns to IDLE, pointer = 1-x, with an ABORT_O pulse.
- Simultaneous LAST and max-length on the same beat: treated as a normal release, no ABORT_O.
- MAX_FRAME=1: every beat releases; ABORT_O only when LAST=0.
- A requester dropping VALID mid-frame keeps its grant until LAST or a watchdog fires. TX_READY_I low stalls the owner and advances only the idle counter.
- Back-to-back frames: each frame pays one IDLE cycle. Pointer alternation guarantees the other requester wins the next contested arbitration.
- Same requester re-requesting with no contention: re-granted after one IDLE cycle.
- GRANT_O is never 11; the datapath never mixes bytes from both requesters.

Test Plan:
- Reset then REQ0 sends 3-byte frame AA,BB,CC (LAST on CC), TX_READY_I=1:
  - GRANT_O=01 one cycle after VALID.
  - TX_WRITE_O high 3 consecutive cycles carrying AA,BB,CC.
  - GRANT_O=00 the cycle after CC; ABORT_O stays 0.
- Both requesters valid from reset, each with 2-byte frames (REQ0: 11,12; REQ1: 21,22):
  - Order on TX is 11,12,21,22.
  - Held valid again: the next frame goes to REQ0, so REQ1 never waits more than one frame.
- REQ1 frame with TX_READY_I low for 5 cycles mid-frame:
  - No TX_WRITE_O during the stall; REQ1_READY_O=0; GRANT_O stays 10.
  - Frame completes intact after the stall; REQ0_READY_O=0 throughout.
- MAX_FRAME=4, REQ0 streams 6 bytes with no LAST:
  - 4 bytes are written, then ABORT_O pulses once and GRANT_O=00.
  - With REQ1 valid, REQ1 is granted next.
- IDLE_TIMEOUT=8, REQ0 sends 1 byte without LAST then drops VALID:
  - ABORT_O pulses 8 cycles after the last beat and the FSM returns to IDLE.
  - Pointer favours REQ1.
- RST_I asserted for one cycle mid-frame of REQ1:
  - Next cycle GRANT_O=00, TX_WRITE_O=0, ABORT_O=0, pointer=0.
  - With both requesters valid afterwards, REQ0 is granted.
